// File: rtl/hdmi_rx_setup_rom.sv
// HDMI RX power-up I2C write table, one registered read per clock.
// Define HDMI_RX_SETUP_EDID_EN to append the internal EDID enable writes.
module hdmi_rx_setup_rom (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] address,
  output logic [7:0] addr,
  output logic [7:0] register,
  output logic [7:0] value,
  output logic [4:0] size
);

  logic [23:0] entry;

`ifdef HDMI_RX_SETUP_EDID_EN
  assign size = 5'd21;
`else
  assign size = 5'd19;
`endif

  // {map address, register, data}
  always_comb begin
    entry = 24'h000000;
    case (address)
      5'd0:  entry = 24'h98F480;
      5'd1:  entry = 24'h98F57C;
      5'd2:  entry = 24'h98F84C;
      5'd3:  entry = 24'h98F964;
      5'd4:  entry = 24'h98FA6C;
      5'd5:  entry = 24'h98FB68;
      5'd6:  entry = 24'h98FD44;
      5'd7:  entry = 24'h980106;
      5'd8:  entry = 24'h9802F5;
      5'd9:  entry = 24'h980380;
      5'd10: entry = 24'h980528;
      5'd11: entry = 24'h9806A6;
      5'd12: entry = 24'h980B44;
      5'd13: entry = 24'h980C42;
      5'd14: entry = 24'h98147F;
      5'd15: entry = 24'h981580;
      5'd16: entry = 24'h981983;
      5'd17: entry = 24'h983340;
      5'd18: entry = 24'h44BA01;
      5'd19: entry = 24'h68C003;
`ifdef HDMI_RX_SETUP_EDID_EN
      5'd20: entry = 24'h644081;
      5'd21: entry = 24'h647401;
`endif
      default: entry = 24'h000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= 8'h00;
      register <= 8'h00;
      value    <= 8'h00;
    end else begin
      addr     <= entry[23:16];
      register <= entry[15:8];
      value    <= entry[7:0];
    end
  end

endmodule

// File: tb/tb_hdmi_rx_setup_rom.sv
// Scoreboard bench for hdmi_rx_setup_rom.
// Build with HDMI_RX_SETUP_EDID_EN to check the extended table.
module tb_hdmi_rx_setup_rom;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] address = 5'd0;
  logic [7:0] addr;
  logic [7:0] register;
  logic [7:0] value;
  logic [4:0] size;

`ifdef HDMI_RX_SETUP_EDID_EN
  localparam logic [4:0] EXP_SIZE = 5'd21;
`else
  localparam logic [4:0] EXP_SIZE = 5'd19;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];
  string       name_q[$];

  hdmi_rx_setup_rom dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .addr(addr),
    .register(register),
    .value(value),
    .size(size)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] tbl(int i);
    case (i)
      0:  return 24'h98F480;
      1:  return 24'h98F57C;
      2:  return 24'h98F84C;
      3:  return 24'h98F964;
      4:  return 24'h98FA6C;
      5:  return 24'h98FB68;
      6:  return 24'h98FD44;
      7:  return 24'h980106;
      8:  return 24'h9802F5;
      9:  return 24'h980380;
      10: return 24'h980528;
      11: return 24'h9806A6;
      12: return 24'h980B44;
      13: return 24'h980C42;
      14: return 24'h98147F;
      15: return 24'h981580;
      16: return 24'h981983;
      17: return 24'h983340;
      18: return 24'h44BA01;
      19: return 24'h68C003;
`ifdef HDMI_RX_SETUP_EDID_EN
      20: return 24'h644081;
      21: return 24'h647401;
`endif
      default: return 24'h000000;
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(logic rst, logic [4:0] a,
                      logic [23:0] e, string nm);
    @(negedge clk);
    reset = rst;
    address = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one registered triple presented per edge
  initial begin
    logic [23:0] e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, {8'h0, addr, register, value}, {8'h0, e});
        check({nm, "_size"}, {27'h0, size}, {27'h0, EXP_SIZE});
      end
    end
  end

  initial begin
    int issued;
    int idx;
    int budget;
    step(1'b1, 5'd0, 24'h000000, "reset0");
    step(1'b1, 5'd0, 24'h000000, "reset1");
    step(1'b0, 5'd0, 24'h98F480, "release");
    #1;
    check("hold_before_edge", {8'h0, addr, register, value}, 32'h0);
    for (int i = 0; i <= int'(EXP_SIZE); i++)
      step(1'b0, i[4:0], tbl(i), $sformatf("sweep%0d", i));
    step(1'b0, 5'd7, 24'h980106, "idx7");
    step(1'b0, 5'd18, 24'h44BA01, "idx18");
    step(1'b0, 5'd19, 24'h68C003, "idx19");
`ifdef HDMI_RX_SETUP_EDID_EN
    step(1'b0, 5'd20, 24'h644081, "idx20");
    step(1'b0, 5'd21, 24'h647401, "idx21");
    step(1'b0, 5'd22, 24'h000000, "idx22");
`else
    step(1'b0, 5'd20, 24'h000000, "idx20");
    step(1'b0, 5'd21, 24'h000000, "idx21");
`endif
    step(1'b0, 5'd31, 24'h000000, "idx31");
    step(1'b0, 5'd5, 24'h98FB68, "steady5");
    step(1'b1, 5'd5, 24'h000000, "pulse_rst");
    step(1'b0, 5'd5, 24'h98FB68, "after_rst");
    issued = 0;
    idx = 0;
    step(1'b0, idx[4:0], tbl(idx), "loop0");
    issued++;
    while (idx < int'(size)) begin
      idx++;
      step(1'b0, idx[4:0], tbl(idx), $sformatf("loop%0d", idx));
      issued++;
    end
    check("loop_count", issued, int'(EXP_SIZE) + 1);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
